debug_controller: RTL and testbench

DEBUG_CONTROLLER -- requirements
Module: debug_controller

---
 rtl/debug_pkg.sv | 28 ++
 rtl/debug_controller_if.sv | 36 +++
 rtl/debug_controller_dump_sequencer.sv | 128 ++++++++++++
 rtl/debug_controller.sv | 135 +++++++++++++
 tb/tb_debug_controller.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// Shared state encodings, command bytes and default sizes for the UART debug controller.
// State ST_BP_LOAD only exists when DBG_BREAKPOINT_EN is defined.
package debug_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_LATCH = 16;
  localparam int DEF_NUM_REG   = 32;
  localparam int DEF_MEM_WORDS = 32;

  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_BP   = 8'h62;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE       = 4'd0;
  localparam state_t ST_RUN        = 4'd1;
  localparam state_t ST_STEP       = 4'd2;
  localparam state_t ST_SEND_PC    = 4'd3;
  localparam state_t ST_SEND_LATCH = 4'd4;
  localparam state_t ST_SEND_REG   = 4'd5;
  localparam state_t ST_SEND_MEM   = 4'd6;
  localparam state_t ST_DONE       = 4'd7;
`ifdef DBG_BREAKPOINT_EN
  localparam state_t ST_BP_LOAD    = 4'd8;
`endif

endpackage

// File: rtl/debug_controller_if.sv
// Bundle of UART command, transmitter handshake, processor status and dump read/address signals.
interface debug_controller_if import debug_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LATCH = DEF_NUM_LATCH,
  parameter int NUM_REG   = DEF_NUM_REG
);
  localparam int LATCH_AW = $clog2(NUM_LATCH);
  localparam int REG_AW   = $clog2(NUM_REG);

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                tx_done;
  logic                prog_finish;
  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   latch_rdata;
  logic [DATA_W-1:0]   reg_rdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic [LATCH_AW-1:0] latch_addr;
  logic [REG_AW-1:0]   reg_addr;
  logic [DATA_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_start;
  logic                dump_active;
  logic                stall;

  modport master (
    input  rx_data, rx_valid, tx_done, prog_finish, pc, latch_rdata, reg_rdata, mem_rdata,
    output latch_addr, reg_addr, mem_addr, tx_data, tx_start, dump_active, stall
  );

  modport slave (
    output rx_data, rx_valid, tx_done, prog_finish, pc, latch_rdata, reg_rdata, mem_rdata,
    input  latch_addr, reg_addr, mem_addr, tx_data, tx_start, dump_active, stall
  );

endinterface

// File: rtl/debug_controller_dump_sequencer.sv
// Walks PC, latch, register and memory sections, launching one tx word per tx_done acknowledge.
module dump_sequencer import debug_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LATCH = DEF_NUM_LATCH,
  parameter int NUM_REG   = DEF_NUM_REG,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int LATCH_AW  = $clog2(NUM_LATCH),
  parameter int REG_AW    = $clog2(NUM_REG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                tx_done,
  input  logic [DATA_W-1:0]   pc,
  input  logic [DATA_W-1:0]   latch_rdata,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [LATCH_AW-1:0] latch_addr,
  output logic [REG_AW-1:0]   reg_addr,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_start,
  output logic                active,
  output logic                finish
);
  localparam logic [LATCH_AW-1:0] LATCH_LAST = LATCH_AW'(NUM_LATCH - 1);
  localparam logic [REG_AW-1:0]   REG_LAST   = REG_AW'(NUM_REG - 1);
  localparam logic [DATA_W-1:0]   MEM_LAST   = DATA_W'(MEM_WORDS - 1);

  state_t              sec_q, sec_d;
  logic                wait_q, wait_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [DATA_W-1:0]   mem_idx_q, mem_idx_d;
  logic [LATCH_AW-1:0] latch_idx_q, latch_idx_d;
  logic [REG_AW-1:0]   reg_idx_q, reg_idx_d;
  logic                done_seen;
  logic                issue;

  // A tx_done in the same cycle as our tx_start cannot acknowledge the word just launched.
  assign done_seen = wait_q && tx_done && !tx_start_q;
  assign issue     = !wait_q && (sec_q inside {ST_SEND_PC, ST_SEND_LATCH, ST_SEND_REG, ST_SEND_MEM});

  always_comb begin
    sec_d       = sec_q;
    wait_d      = wait_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    latch_idx_d = latch_idx_q;
    reg_idx_d   = reg_idx_q;
    mem_idx_d   = mem_idx_q;

    if (done_seen) begin
      wait_d = 1'b0;
      if (sec_q == ST_DONE) sec_d = ST_IDLE;
    end

    // Indices step when a word is launched, so the address already points past it while waiting.
    if (issue) begin
      tx_start_d = 1'b1;
      wait_d     = 1'b1;
      case (sec_q)
        ST_SEND_PC: begin
          tx_data_d = pc;
          sec_d     = ST_SEND_LATCH;
        end
        ST_SEND_LATCH: begin
          tx_data_d = latch_rdata;
          if (latch_idx_q == LATCH_LAST) begin
            latch_idx_d = '0;
            sec_d       = ST_SEND_REG;
          end else begin
            latch_idx_d = latch_idx_q + LATCH_AW'(1);
          end
        end
        ST_SEND_REG: begin
          tx_data_d = reg_rdata;
          if (reg_idx_q == REG_LAST) begin
            reg_idx_d = '0;
            sec_d     = ST_SEND_MEM;
          end else begin
            reg_idx_d = reg_idx_q + REG_AW'(1);
          end
        end
        default: begin
          tx_data_d = mem_rdata;
          if (mem_idx_q == MEM_LAST) begin
            mem_idx_d = '0;
            sec_d     = ST_DONE;
          end else begin
            mem_idx_d = mem_idx_q + DATA_W'(1);
          end
        end
      endcase
    end else if (sec_q == ST_IDLE && start) begin
      sec_d = ST_SEND_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q       <= ST_IDLE;
      wait_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      latch_idx_q <= '0;
      reg_idx_q   <= '0;
      mem_idx_q   <= '0;
    end else begin
      sec_q       <= sec_d;
      wait_q      <= wait_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      latch_idx_q <= latch_idx_d;
      reg_idx_q   <= reg_idx_d;
      mem_idx_q   <= mem_idx_d;
    end
  end

  assign latch_addr = latch_idx_q;
  assign reg_addr   = reg_idx_q;
  assign mem_addr   = mem_idx_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign active     = (sec_q != ST_IDLE);
  assign finish     = done_seen && (sec_q == ST_DONE);

endmodule

// File: rtl/debug_controller.sv
// UART debug controller: decodes run/step commands, freezes the processor and streams a state dump.
// Define DBG_BREAKPOINT_EN to add a loadable PC breakpoint ('b' + 4 address bytes, MSB first).
module debug_controller import debug_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LATCH = DEF_NUM_LATCH,
  parameter int NUM_REG   = DEF_NUM_REG,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input logic                clk,
  input logic                reset,
  debug_controller_if.master dbg
);
  localparam int LATCH_AW = $clog2(NUM_LATCH);
  localparam int REG_AW   = $clog2(NUM_REG);

  // ST_SEND_PC here covers the whole dump; the sequencer tracks the individual sections.
  state_t state_q, state_d;
  logic   start_dump;
  logic   dump_finish;
  logic   bp_hit;
  logic   hit;

`ifdef DBG_BREAKPOINT_EN
  logic [DATA_W-1:0] bp_addr_q, bp_addr_d;
  logic              armed_q, armed_d;
  logic [1:0]        bp_cnt_q, bp_cnt_d;

  assign bp_hit = armed_q && (dbg.pc == bp_addr_q);
`else
  assign bp_hit = 1'b0;
`endif

  assign hit = dbg.prog_finish || bp_hit;

  always_comb begin
    state_d    = state_q;
    start_dump = 1'b0;
`ifdef DBG_BREAKPOINT_EN
    bp_addr_d  = bp_addr_q;
    armed_d    = armed_q;
    bp_cnt_d   = bp_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dbg.rx_valid) begin
          if (dbg.rx_data == CMD_CONT)      state_d = ST_RUN;
          else if (dbg.rx_data == CMD_STEP) state_d = ST_STEP;
`ifdef DBG_BREAKPOINT_EN
          else if (dbg.rx_data == CMD_BP) begin
            state_d  = ST_BP_LOAD;
            bp_cnt_d = 2'd0;
          end
`endif
        end
      end
      ST_RUN: begin
        if (hit) begin
          state_d    = ST_SEND_PC;
          start_dump = 1'b1;
`ifdef DBG_BREAKPOINT_EN
          if (bp_hit) armed_d = 1'b0;
`endif
        end
      end
      ST_STEP: begin
        state_d    = ST_SEND_PC;
        start_dump = 1'b1;
      end
      ST_SEND_PC: begin
        if (dump_finish) state_d = ST_IDLE;
      end
`ifdef DBG_BREAKPOINT_EN
      ST_BP_LOAD: begin
        if (dbg.rx_valid) begin
          bp_addr_d = {bp_addr_q[DATA_W-9:0], dbg.rx_data};
          bp_cnt_d  = bp_cnt_q + 2'd1;
          if (bp_cnt_q == 2'd3) begin
            armed_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

`ifdef DBG_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_addr_q <= '0;
      armed_q   <= 1'b0;
      bp_cnt_q  <= 2'd0;
    end else begin
      bp_addr_q <= bp_addr_d;
      armed_q   <= armed_d;
      bp_cnt_q  <= bp_cnt_d;
    end
  end
`endif

  // The freeze takes effect in the stop cycle itself so the dumped PC is the stopping PC.
  assign dbg.stall = !((state_q == ST_RUN && !hit) || state_q == ST_STEP);

  dump_sequencer #(
    .DATA_W    (DATA_W),
    .NUM_LATCH (NUM_LATCH),
    .NUM_REG   (NUM_REG),
    .MEM_WORDS (MEM_WORDS),
    .LATCH_AW  (LATCH_AW),
    .REG_AW    (REG_AW)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .start       (start_dump),
    .tx_done     (dbg.tx_done),
    .pc          (dbg.pc),
    .latch_rdata (dbg.latch_rdata),
    .reg_rdata   (dbg.reg_rdata),
    .mem_rdata   (dbg.mem_rdata),
    .latch_addr  (dbg.latch_addr),
    .reg_addr    (dbg.reg_addr),
    .mem_addr    (dbg.mem_addr),
    .tx_data     (dbg.tx_data),
    .tx_start    (dbg.tx_start),
    .active      (dbg.dump_active),
    .finish      (dump_finish)
  );

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench: default-size instance A plus a 4/8/2 instance B, both driven from one clock and reset.
module tb_debug_controller;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  debug_controller_if #(.DATA_W(32), .NUM_LATCH(16), .NUM_REG(32)) ia ();
  debug_controller_if #(.DATA_W(32), .NUM_LATCH(4),  .NUM_REG(8))  ib ();

  debug_controller #(.DATA_W(32), .NUM_LATCH(16), .NUM_REG(32), .MEM_WORDS(32)) dut_a (
    .clk(clk), .reset(reset), .dbg(ia)
  );
  debug_controller #(.DATA_W(32), .NUM_LATCH(4), .NUM_REG(8), .MEM_WORDS(2)) dut_b (
    .clk(clk), .reset(reset), .dbg(ib)
  );

  // Memories answer with a section tag in the top nibble and the address below it.
  assign ia.latch_rdata = 32'h1000_0000 | 32'(ia.latch_addr);
  assign ia.reg_rdata   = 32'h2000_0000 | 32'(ia.reg_addr);
  assign ia.mem_rdata   = 32'h3000_0000 | ia.mem_addr;
  assign ib.latch_rdata = 32'h1000_0000 | 32'(ib.latch_addr);
  assign ib.reg_rdata   = 32'h2000_0000 | 32'(ib.reg_addr);
  assign ib.mem_rdata   = 32'h3000_0000 | ib.mem_addr;

  typedef struct {
    logic       vld;
    logic [7:0] b;
    logic       pf;
    logic       s1;
    logic       s2;
    logic       act2;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic g_start(input int w);
    return (w != 0) ? ib.tx_start : ia.tx_start;
  endfunction
  function automatic logic [31:0] g_data(input int w);
    return (w != 0) ? ib.tx_data : ia.tx_data;
  endfunction
  function automatic logic g_act(input int w);
    return (w != 0) ? ib.dump_active : ia.dump_active;
  endfunction
  function automatic logic g_stall(input int w);
    return (w != 0) ? ib.stall : ia.stall;
  endfunction
  function automatic logic [31:0] g_laddr(input int w);
    return (w != 0) ? 32'(ib.latch_addr) : 32'(ia.latch_addr);
  endfunction
  function automatic logic [31:0] g_raddr(input int w);
    return (w != 0) ? 32'(ib.reg_addr) : 32'(ia.reg_addr);
  endfunction
  function automatic logic [31:0] g_maddr(input int w);
    return (w != 0) ? ib.mem_addr : ia.mem_addr;
  endfunction

  task automatic set_done(input int w, input logic v);
    if (w != 0) ib.tx_done = v;
    else        ia.tx_done = v;
  endtask

  task automatic set_rx(input logic v, input logic [7:0] b);
    ia.rx_valid = v; ia.rx_data = b;
    ib.rx_valid = v; ib.rx_data = b;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    set_rx(1'b1, b);
    @(negedge clk);
    set_rx(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input int k, input int nl, input int nr, input logic [31:0] pc_v);
    if (k == 0)       return pc_v;
    if (k <= nl)      return 32'h1000_0000 | 32'(k - 1);
    if (k <= nl + nr) return 32'h2000_0000 | 32'(k - 1 - nl);
    return 32'h3000_0000 | 32'(k - 1 - nl - nr);
  endfunction

  task automatic check_reset_state(input string tag, input int w);
    check({tag, "_stall"},    32'(g_stall(w)), 32'd1);
    check({tag, "_active"},   32'(g_act(w)),   32'd0);
    check({tag, "_tx_start"}, 32'(g_start(w)), 32'd0);
    check({tag, "_tx_data"},  g_data(w),       32'd0);
    check({tag, "_addrs"},    g_laddr(w) | g_raddr(w) | g_maddr(w), 32'd0);
  endtask

  // Transmitter model: acknowledges each word gap cycles after its tx_start.
  task automatic run_dump(input int w, input int nl, input int nr, input int nm,
                          input logic [31:0] pc_v, input int gap, input int hold_k,
                          input int same_k, input int abort_k);
    int total = 1 + nl + nr + nm;
    int k = 0;
    int cnt = -1;
    int budget = 0;
    int bad = 0;
    bit pend = 1'b0;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    logic [31:0] la, ra, ma;
    while (!fin && !aborted && budget < 5000) begin
      @(negedge clk);
      budget++;
      set_done(w, 1'b0);
      if (g_start(w)) begin
        check("no_early_start", 32'(pend), 32'd0);
        check("word", g_data(w), exp_word(k, nl, nr, pc_v));
        if (k > nl + nr) check("other_addrs_zero", g_laddr(w) | g_raddr(w), 32'd0);
        pend = 1'b1;
        cnt  = gap;
        if (k == abort_k) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          check_reset_state("abort", w);
          aborted = 1'b1;
        end else if (k == same_k) begin
          set_done(w, 1'b1);
        end else if (k == hold_k) begin
          la = g_laddr(w); ra = g_raddr(w); ma = g_maddr(w);
          for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (g_start(w) || g_laddr(w) != la || g_raddr(w) != ra || g_maddr(w) != ma) bad++;
          end
          check("hold_static", 32'(bad), 32'd0);
          cnt = 0;
        end
        k++;
      end else if (pend && cnt == 0) begin
        if (k == total) check("active_before_last_done", 32'(g_act(w)), 32'd1);
        set_done(w, 1'b1);
        pend = 1'b0;
        cnt  = -1;
        if (k == total) fin = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
      end
    end
    if (!aborted) begin
      if (!fin) check("dump_timeout", 32'(k), 32'(total));
      @(negedge clk);
      set_done(w, 1'b0);
      check("word_count", 32'(k), 32'(total));
      check("active_after_dump", 32'(g_act(w)), 32'd0);
      check("stall_after_dump", 32'(g_stall(w)), 32'd1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (g_start(w)) bad++;
      end
      check("no_extra_start", 32'(bad), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    vt[0] = '{1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h73, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[2] = '{1'b1, 8'h62, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 8'h63, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b0, 8'h73, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    set_rx(1'b0, 8'h00);
    ia.tx_done = 1'b0; ia.prog_finish = 1'b0; ia.pc = 32'hCAFE_0010;
    ib.tx_done = 1'b0; ib.prog_finish = 1'b0; ib.pc = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset_a", 0);
    check_reset_state("reset_b", 1);

    // Command decode from IDLE, including ignored bytes and stray prog_finish.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      set_rx(vt[i].vld, vt[i].b);
      ia.prog_finish = vt[i].pf;
      @(negedge clk);
      set_rx(1'b0, 8'h00);
      ia.prog_finish = 1'b0;
      check("vec_stall1", 32'(ia.stall), 32'(vt[i].s1));
      @(negedge clk);
      check("vec_stall2", 32'(ia.stall), 32'(vt[i].s2));
      check("vec_active2", 32'(ia.dump_active), 32'(vt[i].act2));
    end

    // Continue, stray 's' while running, finish at cycle 50, full dump.
    do_reset();
    ia.pc = 32'hCAFE_0010;
    drive_byte(8'h63);
    bad = 0;
    for (int c = 1; c < 50; c++) begin
      if (ia.stall !== 1'b0) bad++;
      if (c == 20) set_rx(1'b1, 8'h73);
      @(negedge clk);
      set_rx(1'b0, 8'h00);
    end
    check("run_stall_low", 32'(bad), 32'd0);
    ia.prog_finish = 1'b1;
    @(negedge clk);
    ia.prog_finish = 1'b0;
    check("finish_stall", 32'(ia.stall), 32'd1);
    check("finish_active", 32'(ia.dump_active), 32'd1);
    run_dump(0, 16, 32, 32, 32'hCAFE_0010, 0, -1, -1, -1);

    // Single step with a same-cycle tx_done and a 100-cycle acknowledge stall.
    do_reset();
    ia.pc = 32'h0000_0ABC;
    drive_byte(8'h73);
    check("step_stall_low", 32'(ia.stall), 32'd0);
    @(negedge clk);
    check("step_stall_high", 32'(ia.stall), 32'd1);
    check("step_active", 32'(ia.dump_active), 32'd1);
    run_dump(0, 16, 32, 32, 32'h0000_0ABC, 1, 10, 0, -1);

    // Reset at word 40, then a fresh dump starting at the PC.
    do_reset();
    ia.pc = 32'h5555_AAAA;
    drive_byte(8'h73);
    @(negedge clk);
    run_dump(0, 16, 32, 32, 32'h5555_AAAA, 0, -1, -1, 40);
    ia.pc = 32'h1234_5678;
    drive_byte(8'h73);
    @(negedge clk);
    run_dump(0, 16, 32, 32, 32'h1234_5678, 2, -1, -1, -1);

    // Small instance: 1 + 4 + 8 + 2 words.
    do_reset();
    drive_byte(8'h73);
    @(negedge clk);
    run_dump(1, 4, 8, 2, 32'h0BAD_F00D, 0, -1, -1, -1);

`ifdef DBG_BREAKPOINT_EN
    begin
      logic [7:0] bp_bytes [5];
      bp_bytes[0] = 8'h62; bp_bytes[1] = 8'h00; bp_bytes[2] = 8'h00;
      bp_bytes[3] = 8'h00; bp_bytes[4] = 8'h10;
      do_reset();
      ia.pc = 32'h0;
      for (int i = 0; i < 5; i++) begin
        drive_byte(bp_bytes[i]);
        @(negedge clk);
      end
      drive_byte(8'h63);
      for (int c = 0; c < 100; c++) begin
        if (ia.dump_active) break;
        if (!ia.stall) ia.pc = ia.pc + 32'd4;
        @(negedge clk);
      end
      check("bp_active", 32'(ia.dump_active), 32'd1);
      check("bp_stall", 32'(ia.stall), 32'd1);
      run_dump(0, 16, 32, 32, 32'h0000_0010, 0, -1, -1, -1);
    end
`endif

    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
